hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall scheduler for the 5-stage RV32 core (F,D,E,M,W).
//  - Keeps shadow copies of Rs/Rd/control per stage.
//  - Generates stall/flush for fetch/decode/execute, and ALU forwarding selects.
//  - Handles load-use, taken branch/jump redirect, and a data-memory wait handshake with timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem_ready=0 cycles before abort (>=2)
//  CNT_W        5   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk          in   1   core clock
//  rst          in   1   async, active-high reset
//  Rs1D,Rs2D    in   5   source regs of instr in D
//  RdD          in   5   dest reg of instr in D
//  RegWriteD    in   1   instr in D writes RF
//  MemWriteD    in   1   instr in D is a store
//  ResultSrcD   in   2   2'b01 = load (result from dmem)
//  PCSrcE       in   1   branch taken / jump resolved in E
//  dmem_ready   in   1   dmem completes access of instr in M this cycle
//  StallF       out  1   hold PC
//  StallD       out  1   hold F/D register
//  StallE       out  1   hold D/E and E/M registers (mem wait)
//  FlushD       out  1   bubble F/D register
//  FlushE       out  1   bubble D/E register
//  FlushW       out  1   bubble M/W register
//  ForwardAE    out  2   00 RF, 10 from M (ALUResultM), 01 from W (ResultW)
//  ForwardBE    out  2   same encoding, operand B
//  mem_err      out  1   sticky: a dmem access timed out
// BEHAVIOUR
//  Reset (async): shadow E/M/W cleared (RegWrite=0, Rd=0, load=0, mem=0); state=RUN; cnt=0; mem_err=0.
//   While rst=1: FlushD=FlushE=1, all other outputs 0.
//  Shadow pipe, updated on clk rising:
//   - D->E: {Rs1,Rs2,Rd,RegWrite,load,mem}. Held when StallE; bubble when FlushE.
//   - E->M: held when StallE.
//   - M->W: bubble when StallE or FlushW.
//  Forwarding (combinational, per operand; Rs=Rs1E/Rs2E):
//   - 10 if RegWriteM && RdM!=0 && RdM==Rs
//   - else 01 if RegWriteW && RdW!=0 && RdW==Rs
//   - else 00. M has priority over W.
//  Hazard conditions:
//   - lu = loadE && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)
//   - mw = memM && !dmem_ready && !tmo, where tmo = (state==MEM_WAIT && cnt==MEM_TIMEOUT-1)
//  Output priority (highest first):
//   1. mw: StallF=StallD=StallE=1; no flushes. PCSrcE stays pending and is honoured after release.
//   2. PCSrcE: FlushD=FlushE=1, StallF=StallD=0. Redirect overrides lu; the wrong-path D instr is discarded.
//   3. lu: StallF=StallD=1, FlushE=1. Exactly one bubble, then forward from W.
//   4. Otherwise all 0.
//   FlushW=1 only in the tmo cycle.
//  FSM:
//   - RUN -> MEM_WAIT when mw, cnt<=1.
//   - MEM_WAIT: dmem_ready=1 -> RUN, cnt<=0. Else if tmo -> RUN, cnt<=0, mem_err<=1, M instr dropped via FlushW.
//     Else cnt<=cnt+1.
//   - dmem_ready is ignored when memM=0.
//  Reset mid-wait: immediate return to RUN, counter cleared, nothing held.
//  Latency: all outputs are combinational from shadow regs + D/E inputs; they take effect on the same edge.
// STRUCTURE
//  riscv_pkg: RESULT_LOAD=2'b01; FWD_RF/FWD_W/FWD_M encodings; state enum {RUN,MEM_WAIT}.
//  One sub-module fwd_sel (Rs, RdM, RegWriteM, RdW, RegWriteW -> 2-bit select), instanced twice.
// TESTING
//  1. lw x5 then add x6,x5,x1 -> StallF=StallD=FlushE=1 for 1 cycle; next cycle ForwardAE=01.
//  2. add x5 then sub x7,x5,x5 back-to-back -> ForwardAE=ForwardBE=10, no stall.
//  3. Write to x0 in M, Rs1E=0 -> ForwardAE=00.
//  4. PCSrcE=1 in the same cycle as lu -> FlushD=FlushE=1, StallF=0.
//  5. Store in M, dmem_ready=0 for 3 cycles -> StallF/D/E high exactly 3 cycles; pipeline resumes; mem_err=0.
//  6. dmem_ready=0 held for 16 cycles -> FlushW pulse in cycle 16; mem_err=1 until rst; assert rst mid-wait -> state RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, stage-shadow types and helpers for the pipeline hazard scheduler.
package hazard_ctrl_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {RUN, MEM_WAIT} state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       load;
        logic       mem;
    } stage_e_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem;
    } stage_m_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } stage_w_t;

    // x0 is never a real producer, so it can't create a dependency.
    function automatic logic src_hit(input logic [4:0] rd, input logic wr, input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard scheduler: decode/execute inputs and stall/flush/forward outputs.
interface hazard_ctrl_if;

    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdD;
    logic       RegWriteD;
    logic       MemWriteD;
    logic [1:0] ResultSrcD;
    logic       PCSrcE;
    logic       dmem_ready;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       mem_err;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD, PCSrcE, dmem_ready,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD, PCSrcE, dmem_ready,
        output StallF, StallD, StallE, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// ALU operand forwarding select for one source register; the M stage wins over W.
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic       i_reg_write_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);

    always_comb begin
        if (src_hit(i_rd_m, i_reg_write_m, i_rs)) begin
            o_fwd = FWD_M;
        end else if (src_hit(i_rd_w, i_reg_write_w, i_rs)) begin
            o_fwd = FWD_W;
        end else begin
            o_fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage RV32 core: shadow E/M/W control, load-use,
// branch redirect, forwarding and a data-memory wait handshake with timeout.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input logic           clk,
    input logic           rst,
    hazard_ctrl_if.slave  hz
);

    stage_e_t         r_e;
    stage_m_t         r_m;
    stage_w_t         r_w;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_err;

    stage_e_t   w_d;
    logic       w_load_d;
    logic       w_tmo;
    logic       w_mw;
    logic       w_lu;
    logic       w_stall_e;
    logic       w_flush_e;
    logic       w_flush_w;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_load_d = (hz.ResultSrcD == RESULT_LOAD);
    assign w_d      = '{rs1:       hz.Rs1D,
                        rs2:       hz.Rs2D,
                        rd:        hz.RdD,
                        reg_write: hz.RegWriteD,
                        load:      w_load_d,
                        mem:       w_load_d | hz.MemWriteD};

    assign w_tmo = (r_state == MEM_WAIT) && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_mw  = r_m.mem && !hz.dmem_ready && !w_tmo;
    assign w_lu  = r_e.load && (src_hit(r_e.rd, r_e.reg_write, hz.Rs1D) ||
                                src_hit(r_e.rd, r_e.reg_write, hz.Rs2D));

    hazard_ctrl_fwd_sel u_fwd_a (
        .i_rs          (r_e.rs1),
        .i_rd_m        (r_m.rd),
        .i_reg_write_m (r_m.reg_write),
        .i_rd_w        (r_w.rd),
        .i_reg_write_w (r_w.reg_write),
        .o_fwd         (w_fwd_a)
    );

    hazard_ctrl_fwd_sel u_fwd_b (
        .i_rs          (r_e.rs2),
        .i_rd_m        (r_m.rd),
        .i_reg_write_m (r_m.reg_write),
        .i_rd_w        (r_w.rd),
        .i_reg_write_w (r_w.reg_write),
        .o_fwd         (w_fwd_b)
    );

    // A pending redirect waits out a memory stall; it's re-presented by E after release.
    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        if (rst) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else begin
            hz.FlushW    = w_tmo;
            hz.ForwardAE = w_fwd_a;
            hz.ForwardBE = w_fwd_b;
            if (w_mw) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (w_lu) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

    assign hz.mem_err = r_mem_err;
    assign w_stall_e  = hz.StallE;
    assign w_flush_e  = hz.FlushE;
    assign w_flush_w  = hz.FlushW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            if (!w_stall_e) begin
                r_e <= w_flush_e ? '0 : w_d;
                r_m <= '{rd: r_e.rd, reg_write: r_e.reg_write, mem: r_e.mem};
            end
            if (w_stall_e || w_flush_w) begin
                r_w <= '0;
            end else begin
                r_w <= '{rd: r_m.rd, reg_write: r_m.reg_write};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mw) begin
                        r_state <= MEM_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!r_m.mem || hz.dmem_ready) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-derived expectations queued per step and checked before each edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [10:0] sb_q[$];

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err}
    function automatic logic [10:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fw,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err);
        return {sf, sd, se, fd, fe, fw, fa, fb, err};
    endfunction

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic [1:0] src);
        hz.Rs1D       = rs1;
        hz.Rs2D       = rs2;
        hz.RdD        = rd;
        hz.RegWriteD  = rw;
        hz.MemWriteD  = mw;
        hz.ResultSrcD = src;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    endtask

    // Called at a falling edge with inputs already driven; checks mid-cycle, returns at next fall.
    task automatic step(input string tag, input logic [10:0] e);
        logic [10:0] obs;
        logic [10:0] exp_v;
        sb_q.push_back(e);
        #2;
        obs = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushW,
               hz.ForwardAE, hz.ForwardBE, hz.mem_err};
        exp_v = sb_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
        @(negedge clk);
    endtask

    logic [10:0] zero_v, stall3_v, redirect_v, lu_v;

    initial begin
        zero_v     = mk(0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
        stall3_v   = mk(1, 1, 1, 0, 0, 0, FWD_RF, FWD_RF, 0);
        redirect_v = mk(0, 0, 0, 1, 1, 0, FWD_RF, FWD_RF, 0);
        lu_v       = mk(1, 1, 0, 0, 1, 0, FWD_RF, FWD_RF, 0);

        rst           = 1'b1;
        hz.PCSrcE     = 1'b1;
        hz.dmem_ready = 1'b1;
        nop();
        @(negedge clk);
        step("reset_outputs", redirect_v);
        rst       = 1'b0;
        hz.PCSrcE = 1'b0;
        step("after_reset", zero_v);

        // add x5 ; sub x7,x5,x5
        set_d(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 2'b00);  step("alu_prod", zero_v);
        set_d(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 2'b00);  step("alu_cons_in_d", zero_v);
        nop();                                        step("fwd_m_both", mk(0, 0, 0, 0, 0, 0, FWD_M, FWD_M, 0));
        nop();                                        step("fwd_idle", zero_v);

        // lw x5 ; add x6,x5,x1
        set_d(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, RESULT_LOAD); step("lw_issue", zero_v);
        set_d(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 2'b00);       step("load_use", lu_v);
        step("lu_bubble_once", zero_v);
        nop();                                             step("fwd_w_a", mk(0, 0, 0, 0, 0, 0, FWD_W, FWD_RF, 0));

        // write x0 in M must not forward to Rs1E=0
        set_d(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00);  step("x0_prod", zero_v);
        set_d(5'd0, 5'd6, 5'd9, 1'b1, 1'b0, 2'b00);  step("x0_cons_in_d", zero_v);
        nop();                                        step("x0_no_fwd", zero_v);

        // two writers of x8 back to back: M beats W
        set_d(5'd1, 5'd1, 5'd8, 1'b1, 1'b0, 2'b00);  step("x8_first", zero_v);
        set_d(5'd2, 5'd2, 5'd8, 1'b1, 1'b0, 2'b00);  step("x8_second", zero_v);
        set_d(5'd8, 5'd8, 5'd10, 1'b1, 1'b0, 2'b00); step("x8_cons_in_d", zero_v);
        nop();                                        step("m_over_w", mk(0, 0, 0, 0, 0, 0, FWD_M, FWD_M, 0));

        // redirect in the same cycle as a load-use
        set_d(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, RESULT_LOAD); step("lw2_issue", zero_v);
        set_d(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 2'b00);
        hz.PCSrcE = 1'b1;                                  step("redirect_over_lu", redirect_v);
        hz.PCSrcE = 1'b0;
        nop();                                             step("lw2_mem_ready", zero_v);

        // store waits three cycles; redirect pending during the wait
        set_d(5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 2'b00);  step("sw_issue", zero_v);
        nop();                                        step("sw_in_e", zero_v);
        set_d(5'd1, 5'd1, 5'd11, 1'b1, 1'b0, 2'b00);
        hz.dmem_ready = 1'b0;                         step("mw_1", stall3_v);
        hz.PCSrcE = 1'b1;                             step("mw_2_pcsrc", stall3_v);
        step("mw_3_pcsrc", stall3_v);
        hz.dmem_ready = 1'b1;                         step("mw_release_redirect", redirect_v);
        hz.PCSrcE = 1'b0;
        nop();                                        step("mw_resume", zero_v);

        // store times out after 16 not-ready cycles
        set_d(5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 2'b00);  step("sw2_issue", zero_v);
        nop();                                        step("sw2_in_e", zero_v);
        hz.dmem_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step($sformatf("tmo_stall_%0d", k), stall3_v);
        end
        step("tmo_flushw", mk(0, 0, 0, 0, 0, 1, FWD_RF, FWD_RF, 0));
        step("err_sticky_1", mk(0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 1));
        hz.dmem_ready = 1'b1;
        set_d(5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 2'b00);  step("err_sticky_2", mk(0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 1));
        nop();                                        step("err_sticky_3", mk(0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 1));
        hz.dmem_ready = 1'b0;
        step("wait_again_1", mk(1, 1, 1, 0, 0, 0, FWD_RF, FWD_RF, 1));
        step("wait_again_2", mk(1, 1, 1, 0, 0, 0, FWD_RF, FWD_RF, 1));

        // reset in the middle of a wait
        rst = 1'b1;                                   step("rst_mid_wait", redirect_v);
        rst = 1'b0;                                   step("after_rst_nothing_held", zero_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
